// File: rtl/reg_wr_ctrl.sv
// Register-file write-back controller: arbitrates ALU and decoder write requests,
// serialises different-address conflicts through a one-entry pending buffer.
module reg_wr_ctrl #(
   parameter int DataWidth = 8,
   parameter int AddrWidth = 4,
   parameter int PRIO_ALU  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alu_wr_req,
   input  logic [AddrWidth-1:0] alu_wr_adr,
   input  logic [DataWidth-1:0] alu_result,
   input  logic                 dec_wr_req,
   input  logic [AddrWidth-1:0] dec_wr_adr,
   input  logic [DataWidth-1:0] dec_literal,
   output logic                 alu_wr_ack,
   output logic                 dec_wr_ack,
   output logic                 stall,
   output logic                 wr_collision,
   output logic                 sel_reg_in_alu_decoder,
   output logic [DataWidth-1:0] result,
   output logic [DataWidth-1:0] literal_adr,
   output logic                 reg_wr_en,
   output logic [AddrWidth-1:0] reg_wr_adr
);

   typedef enum logic [1:0] {IDLE, WR, WR_PEND} state_t;

   state_t               r_state;
   logic                 r_stall;
   logic                 r_collision;
   logic                 r_sel;
   logic [DataWidth-1:0] r_result;
   logic [DataWidth-1:0] r_literal;
   logic                 r_wr_en;
   logic [AddrWidth-1:0] r_wr_adr;
   logic                 r_pend_sel;
   logic [AddrWidth-1:0] r_pend_adr;
   logic [DataWidth-1:0] r_pend_data;

   logic w_alu_acc;
   logic w_dec_acc;
   logic w_both;
   logic w_same_adr;
   logic w_win_alu;

   assign w_alu_acc  = alu_wr_req & ~r_stall;
   assign w_dec_acc  = dec_wr_req & ~r_stall;
   assign w_both     = w_alu_acc & w_dec_acc;
   assign w_same_adr = (alu_wr_adr == dec_wr_adr);
   assign w_win_alu  = w_alu_acc & (~w_dec_acc | (PRIO_ALU != 0));

   // The pending buffer is occupied exactly while stall is high in WR.
   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_stall     <= 1'b0;
         r_collision <= 1'b0;
         r_sel       <= 1'b0;
         r_result    <= '0;
         r_literal   <= '0;
         r_wr_en     <= 1'b0;
         r_wr_adr    <= '0;
         r_pend_sel  <= 1'b0;
         r_pend_adr  <= '0;
         r_pend_data <= '0;
      end else begin
         r_collision <= 1'b0;
         if (r_state == WR && r_stall) begin
            r_state  <= WR_PEND;
            r_stall  <= 1'b0;
            r_wr_en  <= 1'b1;
            r_sel    <= r_pend_sel;
            r_wr_adr <= r_pend_adr;
            if (r_pend_sel) r_result  <= r_pend_data;
            else            r_literal <= r_pend_data;
         end else if (w_alu_acc || w_dec_acc) begin
            r_state <= WR;
            r_wr_en <= 1'b1;
            if (w_win_alu) begin
               r_sel    <= 1'b1;
               r_wr_adr <= alu_wr_adr;
               r_result <= alu_result;
            end else begin
               r_sel     <= 1'b0;
               r_wr_adr  <= dec_wr_adr;
               r_literal <= dec_literal;
            end
            if (w_both && w_same_adr) begin
               r_collision <= 1'b1;
            end else if (w_both) begin
               r_stall     <= 1'b1;
               r_pend_sel  <= ~w_win_alu;
               r_pend_adr  <= w_win_alu ? dec_wr_adr  : alu_wr_adr;
               r_pend_data <= w_win_alu ? dec_literal : alu_result;
            end
         end else begin
            r_state <= IDLE;
            r_wr_en <= 1'b0;
         end
      end
   end

   assign alu_wr_ack             = w_alu_acc;
   assign dec_wr_ack             = w_dec_acc;
   assign stall                  = r_stall;
   assign wr_collision           = r_collision;
   assign sel_reg_in_alu_decoder = r_sel;
   assign result                 = r_result;
   assign literal_adr            = r_literal;
   assign reg_wr_en              = r_wr_en;
   assign reg_wr_adr             = r_wr_adr;

endmodule
